// File: rtl/lfsr4_checker.sv
// Serial sink for the 4-bit LFSR generator (b(t) = b(t-3) ^ b(t-4)).
// Self-synchronises on four acquired bits, then checks each valid bit against a free-running local reference.
module lfsr4_checker #(
    parameter int CNT_W       = 8,
    parameter int LOSS_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic             stuck_zero
);

    typedef enum logic [0:0] {
        ST_ACQUIRE = 1'b0,
        ST_LOCKED  = 1'b1
    } state_t;

    localparam logic [2:0]       LOSS_T  = 3'(LOSS_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Next bit of the sequence from the four most recent bits (h[0] newest).
    function automatic logic lfsr_predict(input logic [3:0] hist);
        return hist[2] ^ hist[3];
    endfunction

    state_t           state_r;
    logic [3:0]       hist_r;
    logic [1:0]       fill_r;
    logic [2:0]       miss_r;
    logic             locked_r;
    logic             err_pulse_r;
    logic [CNT_W-1:0] err_count_r;
    logic             stuck_zero_r;

    logic             predicted_s;
    logic             mismatch_s;
    logic [3:0]       acq_hist_s;
    logic [3:0]       ref_hist_s;
    logic [2:0]       miss_next_s;

    // Prediction, comparison and candidate next-history values.
    always_comb begin
        predicted_s = lfsr_predict(hist_r);
        acq_hist_s  = {hist_r[2:0], bit_in};
        ref_hist_s  = {hist_r[2:0], predicted_s};
        mismatch_s  = bit_valid && (state_r == ST_LOCKED) && (bit_in != predicted_s);
        miss_next_s = miss_r + 3'd1;
    end

    // Acquire/lock state machine, history, loss detection and error counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_ACQUIRE;
            hist_r       <= 4'd0;
            fill_r       <= 2'd0;
            miss_r       <= 3'd0;
            locked_r     <= 1'b0;
            err_pulse_r  <= 1'b0;
            err_count_r  <= '0;
            stuck_zero_r <= 1'b0;
        end else begin
            err_pulse_r <= mismatch_s;

            // clear wins over a same-edge increment; the pulse above is unaffected
            if (clear) begin
                err_count_r <= '0;
            end else if (mismatch_s && (err_count_r != CNT_MAX)) begin
                err_count_r <= err_count_r + CNT_ONE;
            end else begin
                err_count_r <= err_count_r;
            end

            if (bit_valid) begin
                case (state_r)
                    ST_ACQUIRE: begin
                        hist_r <= acq_hist_s;
                        if (fill_r == 2'd3) begin
                            fill_r <= 2'd0;
                            if (acq_hist_s != 4'd0) begin
                                state_r      <= ST_LOCKED;
                                locked_r     <= 1'b1;
                                stuck_zero_r <= 1'b0;
                                miss_r       <= 3'd0;
                            end else begin
                                stuck_zero_r <= 1'b1;
                            end
                        end else begin
                            fill_r <= fill_r + 2'd1;
                        end
                    end
                    ST_LOCKED: begin
                        // history follows the reference, so one bad bit is counted once
                        if (mismatch_s && (miss_next_s == LOSS_T)) begin
                            state_r  <= ST_ACQUIRE;
                            locked_r <= 1'b0;
                            hist_r   <= 4'd0;
                            fill_r   <= 2'd0;
                            miss_r   <= 3'd0;
                        end else if (mismatch_s) begin
                            hist_r <= ref_hist_s;
                            miss_r <= miss_next_s;
                        end else begin
                            hist_r <= ref_hist_s;
                            miss_r <= 3'd0;
                        end
                    end
                    default: begin
                        state_r  <= ST_ACQUIRE;
                        locked_r <= 1'b0;
                        hist_r   <= 4'd0;
                        fill_r   <= 2'd0;
                        miss_r   <= 3'd0;
                    end
                endcase
            end
        end
    end

    assign locked     = locked_r;
    assign err_pulse  = err_pulse_r;
    assign err_count  = err_count_r;
    assign stuck_zero = stuck_zero_r;

endmodule

// File: tb/tb_lfsr4_checker.sv
// Bench for lfsr4_checker: two instances (default and CNT_W=2/LOSS_THRESH=7) driven together,
// checked against a table-lookup model of the reference sequence.
module tb_lfsr4_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       clear;
    logic       locked_a, err_pulse_a, stuck_zero_a;
    logic [7:0] err_count_a;
    logic       locked_b, err_pulse_b, stuck_zero_b;
    logic [1:0] err_count_b;

    lfsr4_checker #(.CNT_W(8), .LOSS_THRESH(4)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
        .locked(locked_a), .err_pulse(err_pulse_a), .err_count(err_count_a), .stuck_zero(stuck_zero_a)
    );

    lfsr4_checker #(.CNT_W(2), .LOSS_THRESH(7)) dut_sat (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
        .locked(locked_b), .err_pulse(err_pulse_b), .err_count(err_count_b), .stuck_zero(stuck_zero_b)
    );

    int checks   = 0;
    int failures = 0;

    int ref_seq[15] = '{0, 0, 1, 1, 0, 1, 0, 1, 1, 1, 1, 0, 0, 0, 1};
    int thr[2]      = '{4, 7};
    int cmax[2]     = '{255, 3};

    // Model: instance 0 = dut, instance 1 = dut_sat
    int m_locked[2], m_pulse[2], m_count[2], m_stuck[2], m_fill[2], m_ptr[2], m_run[2];
    int m_acq[2][4];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_locked[i] = 0; m_pulse[i] = 0; m_count[i] = 0; m_stuck[i] = 0;
            m_fill[i] = 0; m_ptr[i] = 0; m_run[i] = 0;
            for (int k = 0; k < 4; k++) m_acq[i][k] = 0;
        end
    endtask

    // Locking = finding where the four acquired bits sit in the 15-entry table.
    task automatic model_step(input int v, input int b, input int c);
        for (int i = 0; i < 2; i++) begin
            m_pulse[i] = 0;
            if (v != 0) begin
                if (m_locked[i] == 0) begin
                    m_acq[i][m_fill[i]] = b;
                    m_fill[i]++;
                    if (m_fill[i] == 4) begin
                        m_fill[i] = 0;
                        if (m_acq[i][0] + m_acq[i][1] + m_acq[i][2] + m_acq[i][3] == 0) begin
                            m_stuck[i] = 1;
                        end else begin
                            for (int p = 0; p < 15; p++) begin
                                int ok = 1;
                                for (int k = 0; k < 4; k++)
                                    if (ref_seq[(p + k) % 15] != m_acq[i][k]) ok = 0;
                                if (ok != 0) m_ptr[i] = (p + 4) % 15;
                            end
                            m_locked[i] = 1; m_stuck[i] = 0; m_run[i] = 0;
                        end
                    end
                end else begin
                    int e = ref_seq[m_ptr[i]];
                    m_ptr[i] = (m_ptr[i] + 1) % 15;
                    if (b != e) begin
                        m_pulse[i] = 1;
                        if (c == 0 && m_count[i] < cmax[i]) m_count[i]++;
                        m_run[i]++;
                        if (m_run[i] == thr[i]) begin
                            m_locked[i] = 0; m_fill[i] = 0; m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            if (c != 0) m_count[i] = 0;
        end
    endtask

    task automatic step(input int v, input int b, input int c);
        bit_valid = v[0];
        bit_in    = b[0];
        clear     = c[0];
        @(posedge clk);
        model_step(v, b, c);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; clear = 1'b0;
        model_reset();
        #10;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; clear = 1'b0;
        #2 rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({locked_a, err_pulse_a, stuck_zero_a, err_count_a} !== 11'd0) begin
            failures++;
            $display("FAIL reset_a got=%b exp=%b", {locked_a, err_pulse_a, stuck_zero_a, err_count_a}, 11'd0);
        end
        checks++;
        if ({locked_b, err_pulse_b, stuck_zero_b, err_count_b} !== 5'd0) begin
            failures++;
            $display("FAIL reset_b got=%b exp=%b", {locked_b, err_pulse_b, stuck_zero_b, err_count_b}, 5'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_clean_lock();
        do_reset();
        for (int n = 0; n < 30; n++) begin
            step(1, ref_seq[n % 15], 0);
            checks++;
            if ({locked_a, err_pulse_a, stuck_zero_a, err_count_a} !==
                {1'(m_locked[0]), 1'(m_pulse[0]), 1'(m_stuck[0]), 8'(m_count[0])}) begin
                failures++;
                $display("FAIL clean_lock bit=%0d got=%b exp=%b", n, {locked_a, err_pulse_a, stuck_zero_a, err_count_a},
                         {1'(m_locked[0]), 1'(m_pulse[0]), 1'(m_stuck[0]), 8'(m_count[0])});
            end
            if (n == 3) begin
                checks++;
                if (locked_a !== 1'b1) begin
                    failures++;
                    $display("FAIL lock_after_4th got=%b exp=1", locked_a);
                end
            end
        end
    endtask

    task automatic test_single_error();
        int pulses = 0;
        do_reset();
        for (int n = 0; n < 30; n++) begin
            step(1, ref_seq[n % 15] ^ ((n == 10) ? 1 : 0), 0);
            if (err_pulse_a === 1'b1) pulses++;
            checks++;
            if ({locked_a, err_pulse_a, stuck_zero_a, err_count_a} !==
                {1'(m_locked[0]), 1'(m_pulse[0]), 1'(m_stuck[0]), 8'(m_count[0])}) begin
                failures++;
                $display("FAIL single_error bit=%0d got=%b exp=%b", n, {locked_a, err_pulse_a, stuck_zero_a, err_count_a},
                         {1'(m_locked[0]), 1'(m_pulse[0]), 1'(m_stuck[0]), 8'(m_count[0])});
            end
        end
        checks++;
        if (pulses != 1 || err_count_a !== 8'd1 || locked_a !== 1'b1) begin
            failures++;
            $display("FAIL single_error_total pulses=%0d count=%0d locked=%b exp pulses=1 count=1 locked=1",
                     pulses, err_count_a, locked_a);
        end
    endtask

    task automatic test_loss_reacquire();
        do_reset();
        for (int n = 0; n < 30; n++) begin
            step(1, ref_seq[n % 15] ^ ((n >= 8 && n <= 11) ? 1 : 0), 0);
            checks++;
            if ({locked_a, err_pulse_a, stuck_zero_a, err_count_a} !==
                {1'(m_locked[0]), 1'(m_pulse[0]), 1'(m_stuck[0]), 8'(m_count[0])}) begin
                failures++;
                $display("FAIL loss_reacquire bit=%0d got=%b exp=%b", n, {locked_a, err_pulse_a, stuck_zero_a, err_count_a},
                         {1'(m_locked[0]), 1'(m_pulse[0]), 1'(m_stuck[0]), 8'(m_count[0])});
            end
            if (n == 11 || n == 15) begin
                checks++;
                if (locked_a !== ((n == 15) ? 1'b1 : 1'b0) || err_count_a !== 8'd4) begin
                    failures++;
                    $display("FAIL loss_point bit=%0d locked=%b count=%0d exp locked=%0d count=4",
                             n, locked_a, err_count_a, (n == 15) ? 1 : 0);
                end
            end
        end
    endtask

    task automatic test_unseeded();
        do_reset();
        for (int n = 0; n < 20; n++) begin
            step(1, 0, 0);
            checks++;
            if ({locked_a, stuck_zero_a} !== {1'b0, ((n >= 3) ? 1'b1 : 1'b0)} ||
                stuck_zero_a !== 1'(m_stuck[0])) begin
                failures++;
                $display("FAIL unseeded bit=%0d locked=%b stuck=%b exp locked=0 stuck=%0d",
                         n, locked_a, stuck_zero_a, m_stuck[0]);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int n = 0; n < 21; n++) begin
            step(1, ref_seq[n % 15] ^ ((n == 6 || n == 9 || n == 12 || n == 15 || n == 18) ? 1 : 0), 0);
            checks++;
            if ({locked_b, err_pulse_b, stuck_zero_b, err_count_b} !==
                {1'(m_locked[1]), 1'(m_pulse[1]), 1'(m_stuck[1]), 2'(m_count[1])}) begin
                failures++;
                $display("FAIL saturation bit=%0d got=%b exp=%b", n, {locked_b, err_pulse_b, stuck_zero_b, err_count_b},
                         {1'(m_locked[1]), 1'(m_pulse[1]), 1'(m_stuck[1]), 2'(m_count[1])});
            end
        end
        checks++;
        if (err_count_b !== 2'd3 || locked_b !== 1'b1) begin
            failures++;
            $display("FAIL saturation_hold count=%0d locked=%b exp count=3 locked=1", err_count_b, locked_b);
        end
        step(1, 1 - ref_seq[21 % 15], 1);
        checks++;
        if (err_count_b !== 2'd0 || err_pulse_b !== 1'b1 || locked_b !== 1'b1) begin
            failures++;
            $display("FAIL clear_vs_error count=%0d pulse=%b locked=%b exp count=0 pulse=1 locked=1",
                     err_count_b, err_pulse_b, locked_b);
        end
    endtask

    task automatic test_gaps_and_reset();
        do_reset();
        for (int n = 0; n < 30; n++) begin
            step(1, ref_seq[n % 15] ^ ((n == 10) ? 1 : 0), 0);
            checks++;
            if ({locked_a, err_pulse_a, stuck_zero_a, err_count_a} !==
                {1'(m_locked[0]), 1'(m_pulse[0]), 1'(m_stuck[0]), 8'(m_count[0])}) begin
                failures++;
                $display("FAIL gaps_valid bit=%0d got=%b exp=%b", n, {locked_a, err_pulse_a, stuck_zero_a, err_count_a},
                         {1'(m_locked[0]), 1'(m_pulse[0]), 1'(m_stuck[0]), 8'(m_count[0])});
            end
            step(0, int'($urandom_range(0, 1)), 0);
            checks++;
            if ({locked_a, err_pulse_a, stuck_zero_a, err_count_a} !==
                {1'(m_locked[0]), 1'(m_pulse[0]), 1'(m_stuck[0]), 8'(m_count[0])}) begin
                failures++;
                $display("FAIL gaps_idle bit=%0d got=%b exp=%b", n, {locked_a, err_pulse_a, stuck_zero_a, err_count_a},
                         {1'(m_locked[0]), 1'(m_pulse[0]), 1'(m_stuck[0]), 8'(m_count[0])});
            end
        end
        checks++;
        if (locked_a !== 1'b1 || err_count_a !== 8'd1) begin
            failures++;
            $display("FAIL gaps_final locked=%b count=%0d exp locked=1 count=1", locked_a, err_count_a);
        end
        #3 rst = 1'b0;
        #1;
        checks++;
        if (locked_a !== 1'b0 || err_count_a !== 8'd0) begin
            failures++;
            $display("FAIL async_reset locked=%b count=%0d exp locked=0 count=0", locked_a, err_count_a);
        end
        model_reset();
        #6 rst = 1'b1;
    endtask

    task automatic test_random();
        int s;
        int v, b, c;
        do_reset();
        s = int'($urandom_range(0, 14));
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(0, 3) != 0) ? 1 : 0;
            c = ($urandom_range(0, 24) == 0) ? 1 : 0;
            if (v != 0) begin
                b = ref_seq[s % 15] ^ (($urandom_range(0, 7) == 0) ? 1 : 0);
                s++;
            end else begin
                b = int'($urandom_range(0, 1));
            end
            step(v, b, c);
            checks++;
            if ({locked_a, err_pulse_a, stuck_zero_a, err_count_a} !==
                {1'(m_locked[0]), 1'(m_pulse[0]), 1'(m_stuck[0]), 8'(m_count[0])}) begin
                failures++;
                $display("FAIL random_a cyc=%0d got=%b exp=%b", n, {locked_a, err_pulse_a, stuck_zero_a, err_count_a},
                         {1'(m_locked[0]), 1'(m_pulse[0]), 1'(m_stuck[0]), 8'(m_count[0])});
            end
            checks++;
            if ({locked_b, err_pulse_b, stuck_zero_b, err_count_b} !==
                {1'(m_locked[1]), 1'(m_pulse[1]), 1'(m_stuck[1]), 2'(m_count[1])}) begin
                failures++;
                $display("FAIL random_b cyc=%0d got=%b exp=%b", n, {locked_b, err_pulse_b, stuck_zero_b, err_count_b},
                         {1'(m_locked[1]), 1'(m_pulse[1]), 1'(m_stuck[1]), 2'(m_count[1])});
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_single_error();
        test_loss_reacquire();
        test_unseeded();
        test_saturation();
        test_gaps_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr4_checker.md
Name: lfsr4_checker

Overview:
- Downstream consumer of the 4-bit LFSR serial generator.
- Receives its serial output stream, self-synchronises to the sequence, then checks each subsequent bit against a free-running local reference.
- Reports lock status, per-bit error pulses and a saturating error count.
- Used as the on-chip BIST sink for the LFSR benchmark datapath.

Parameters:
CNT_W, 8, width of the saturating error counter (>=2)
LOSS_THRESH, 4, consecutive mismatches that declare loss of sync (1..7)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (rst=0 resets)
bit_in  input  1  serial bit from the LFSR generator output
bit_valid  input  1  bit_in is sampled only on edges where bit_valid=1
clear  input  1  synchronous clear of err_count
locked  output  1  checker is synchronised and comparing
err_pulse  output  1  one-cycle pulse, registered, per mismatching valid bit
err_count  output  CNT_W  saturating count of mismatches
stuck_zero  output  1  last 4 acquired bits were all zero (generator unseeded)

Behaviour:
- Sequence definition:
  - Generator recurrence is b(t) = b(t-3) XOR b(t-4).
  - Local history h[3:0]; h[0] is the newest bit, h[3] the oldest.
  - predicted = h[2] XOR h[3].
- Reset (rst=0, asynchronous): state=ACQUIRE, h=0, fill count=0, miss_run=0, locked=0, err_pulse=0, err_count=0, stuck_zero=0.
- When bit_valid=0, no state, history or counter changes occur, and err_pulse is 0 on the following cycle.
- ACQUIRE state:
  - Each valid bit shifts in: h <= {h[2:0], bit_in}, and fill increments.
  - On the 4th valid bit, if the resulting h != 0: go to LOCKED and set locked=1 (visible the cycle after that edge). Set miss_run=0.
  - If the resulting h == 0: stay in ACQUIRE, set fill=0, set stuck_zero=1.
  - stuck_zero clears on entry to LOCKED and on reset.
  - No comparisons and no err_pulse in ACQUIRE.
- LOCKED state, per valid bit:
  - Compare bit_in with predicted.
  - History always advances with predicted, not bit_in: h <= {h[2:0], predicted}. A single corrupted bit therefore counts exactly once.
  - Match: miss_run <= 0.
  - Mismatch: err_pulse=1 next cycle, err_count increments unless all-ones (saturate), miss_run increments.
  - If a mismatch makes miss_run reach LOSS_THRESH: the error is counted, then state=ACQUIRE, locked=0 next cycle, h=0, fill=0, miss_run=0.
- Latency: the first compared bit is the 5th valid bit after entering ACQUIRE. err_pulse and err_count reflect a bit one cycle after the edge that sampled it.
- clear=1 forces err_count=0 on that edge. It takes priority over a simultaneous increment; err_pulse still fires.
- clear does not affect lock state or history.
- Reset mid-operation drops locked and zeroes all counters immediately, independent of clk.
- Reference sequence (generator seeded state 4'b0001, period 15): 0,0,1,1,0,1,0,1,1,1,1,0,0,0,1, repeating.

Test Plan:
- Clean lock: feed the reference sequence for 30 valid bits, bit_valid=1 continuously -> locked=1 from the cycle after the 4th bit, err_count=0, err_pulse never asserts.
- Single error: same stream with bit index 10 inverted (1->0) -> exactly one err_pulse, the cycle after bit 10 is sampled; err_count=1; locked stays 1.
- Loss and reacquire (LOSS_THRESH=4): after lock, invert 4 consecutive bits (indices 8..11) -> err_count=4, locked=0 after the 4th; resume the clean sequence -> locked=1 again 4 valid bits later, err_count holds at 4.
- Unseeded generator: 20 valid zero bits -> locked stays 0; stuck_zero=1 from the cycle after the 4th bit and remains 1.
- Saturation and clear (CNT_W=2, LOSS_THRESH=7): after lock, inject 5 isolated errors, each separated by matching bits -> err_count stops at 3.
  - Then assert clear on the same edge as a mismatch -> err_count=0 and err_pulse=1.
- Gaps and reset: toggle bit_valid 1/0 on alternate cycles with the clean stream -> identical lock and error results to the continuous case.
  - Then pull rst low mid-lock, asynchronously -> locked=0 and err_count=0 before the next clk edge.
